// File: rtl/bus_access_scheduler.sv
// Two-port scheduler that acquires the 68k bus via BR/BG/BGACK and feeds
// accepted requests one at a time to the bus-cycle engine.
module bus_access_scheduler #(
  parameter int IDLE_HOLD    = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int BG_TIMEOUT   = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [23:0] a_addr,
  input  logic [1:0]  a_size,
  input  logic        a_read,
  input  logic [2:0]  a_fc,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [23:0] b_addr,
  input  logic [1:0]  b_size,
  input  logic        b_read,
  input  logic [2:0]  b_fc,
  input  logic [31:0] b_wdata,
  output logic        eng_start,
  output logic [23:0] eng_addr,
  output logic [1:0]  eng_size,
  output logic        eng_read,
  output logic [2:0]  eng_fc,
  output logic [31:0] eng_wdata,
  input  logic        eng_busy,
  input  logic        eng_done,
  output logic        eng_src,
  input  logic        bg_n,
  input  logic        as_n,
  input  logic        bgack_n_in,
  output logic        br_drive,
  output logic        bgack_drive,
  output logic        owned,
  output logic        bg_timeout_err
);

  localparam int RC_W = $clog2(BG_TIMEOUT + 1);
  localparam int IC_W = $clog2(IDLE_HOLD + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE, REQ_BUS, OWN, ISSUE, WAIT_DONE, RELEASE
  } state_t;

  state_t          state_reg;
  logic [RC_W-1:0] req_cnt_reg;
  logic [IC_W-1:0] idle_cnt_reg;
  logic [SC_W-1:0] starve_cnt_reg;

  logic a_win;
  logic b_win;
  logic in_own;

  // B normally loses to A, but takes the slot once it has been passed over
  // STARVE_LIMIT times in a row.
  assign b_win  = b_valid && (!a_valid || (starve_cnt_reg == SC_W'(STARVE_LIMIT)));
  assign a_win  = a_valid && !b_win;
  assign in_own = !sys_rst && (state_reg == OWN);

  // Ready is combinational so the handshake completes in the cycle valid is
  // seen; a requester that withdraws is never accepted.
  assign a_ready = in_own && a_win;
  assign b_ready = in_own && b_win;
  assign owned   = bgack_drive;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      req_cnt_reg    <= '0;
      idle_cnt_reg   <= '0;
      starve_cnt_reg <= '0;
      br_drive       <= 1'b0;
      bgack_drive    <= 1'b0;
      bg_timeout_err <= 1'b0;
      eng_start      <= 1'b0;
      eng_src        <= 1'b0;
      eng_addr       <= '0;
      eng_size       <= '0;
      eng_read       <= 1'b0;
      eng_fc         <= '0;
      eng_wdata      <= '0;
    end else begin
      eng_start <= 1'b0;
      if (!b_valid) starve_cnt_reg <= '0;

      case (state_reg)
        IDLE: begin
          req_cnt_reg <= '0;
          if (a_valid || b_valid) begin
            state_reg <= REQ_BUS;
            br_drive  <= 1'b1;
          end
        end

        REQ_BUS: begin
          if (!bg_n && as_n && bgack_n_in) begin
            state_reg    <= OWN;
            bgack_drive  <= 1'b1;
            br_drive     <= 1'b0;
            req_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
          end else if (req_cnt_reg == RC_W'(BG_TIMEOUT - 1)) begin
            state_reg      <= IDLE;
            bg_timeout_err <= 1'b1;
            br_drive       <= 1'b0;
            req_cnt_reg    <= '0;
          end else begin
            req_cnt_reg <= req_cnt_reg + RC_W'(1);
          end
        end

        OWN: begin
          if (a_ready || b_ready) begin
            state_reg    <= ISSUE;
            idle_cnt_reg <= '0;
            eng_src      <= b_ready;
            eng_addr     <= b_ready ? b_addr  : a_addr;
            eng_size     <= b_ready ? b_size  : a_size;
            eng_read     <= b_ready ? b_read  : a_read;
            eng_fc       <= b_ready ? b_fc    : a_fc;
            eng_wdata    <= b_ready ? b_wdata : a_wdata;
            // Start straight away if the engine is free: one cycle latency.
            eng_start    <= !eng_busy;
            if (b_ready)
              starve_cnt_reg <= '0;
            else if (b_valid && (starve_cnt_reg != SC_W'(STARVE_LIMIT)))
              starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
          end else if (idle_cnt_reg == IC_W'(IDLE_HOLD - 1)) begin
            state_reg    <= RELEASE;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + IC_W'(1);
          end
        end

        ISSUE: begin
          if (eng_start)
            state_reg <= WAIT_DONE;
          else if (!eng_busy)
            eng_start <= 1'b1;
        end

        WAIT_DONE: begin
          if (eng_done) begin
            state_reg    <= OWN;
            idle_cnt_reg <= '0;
          end
        end

        RELEASE: begin
          bgack_drive <= 1'b0;
          state_reg   <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_access_scheduler.sv
// Directed bench for bus_access_scheduler: a cycle table for the basic
// acquire/issue flow plus sequences for arbitration, timeout, hold and reset.
module tb_bus_access_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        a_valid, a_ready, a_read;
  logic [23:0] a_addr;
  logic [1:0]  a_size;
  logic [2:0]  a_fc;
  logic [31:0] a_wdata;
  logic        b_valid, b_ready, b_read;
  logic [23:0] b_addr;
  logic [1:0]  b_size;
  logic [2:0]  b_fc;
  logic [31:0] b_wdata;
  logic        eng_start, eng_read, eng_busy, eng_done, eng_src;
  logic [23:0] eng_addr;
  logic [1:0]  eng_size;
  logic [2:0]  eng_fc;
  logic [31:0] eng_wdata;
  logic        bg_n, as_n, bgack_n_in;
  logic        br_drive, bgack_drive, owned, bg_timeout_err;

  int checks = 0;
  int failures = 0;

  bus_access_scheduler #(.IDLE_HOLD(16), .STARVE_LIMIT(4), .BG_TIMEOUT(1023)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_size(a_size),
    .a_read(a_read), .a_fc(a_fc), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_size(b_size),
    .b_read(b_read), .b_fc(b_fc), .b_wdata(b_wdata),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_size(eng_size),
    .eng_read(eng_read), .eng_fc(eng_fc), .eng_wdata(eng_wdata),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_src(eng_src),
    .bg_n(bg_n), .as_n(as_n), .bgack_n_in(bgack_n_in),
    .br_drive(br_drive), .bgack_drive(bgack_drive), .owned(owned),
    .bg_timeout_err(bg_timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        a_valid;
    logic        bg_n;
    logic        eng_done;
    logic        br;
    logic        bgack;
    logic        a_rdy;
    logic        start;
    logic        src;
    logic [23:0] addr;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int av, input int bgn, input int done, input int br,
                              input int bgk, input int ar, input int st, input int src,
                              input int ad);
    vec_t r;
    r.a_valid  = 1'(av);
    r.bg_n     = 1'(bgn);
    r.eng_done = 1'(done);
    r.br       = 1'(br);
    r.bgack    = 1'(bgk);
    r.a_rdy    = 1'(ar);
    r.start    = 1'(st);
    r.src      = 1'(src);
    r.addr     = 24'(ad);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    a_valid = 0; b_valid = 0; eng_busy = 0; eng_done = 0;
    bg_n = 1; as_n = 1; bgack_n_in = 1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic acquire();
    int n = 0;
    bg_n = 1'b0;
    while (!bgack_drive && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("acquire_bgack", bgack_drive, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(a_ready || b_ready) && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ready_seen", a_ready | b_ready, 1);
  endtask

  initial begin
    int n;
    int done_cnt;
    int grants;
    logic last_b;
    logic [9:0] exp_grant;

    a_addr = 24'hDFF180; a_size = 2'd1; a_read = 1'b0; a_fc = 3'd5; a_wdata = 32'h12345678;
    b_addr = 24'h200000; b_size = 2'd2; b_read = 1'b1; b_fc = 3'd6; b_wdata = 32'hCAFEF00D;
    sys_rst = 1'b1;
    do_reset();

    // Reset state
    chk("rst_br", br_drive, 0);
    chk("rst_bgack", bgack_drive, 0);
    chk("rst_owned", owned, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_err", bg_timeout_err, 0);
    chk("rst_src", eng_src, 0);
    chk("rst_addr", eng_addr, 0);
    chk("rst_ready", a_ready | b_ready, 0);

    // Basic flow: request, BG after 5 cycles, accept, issue, done, BG rises in OWN
    //             av bgn dn br bgk ar st src addr
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 24'hDFF180);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 24'hDFF180);
    vecs[9]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 24'hDFF180);
    vecs[10] = mk(0, 1, 0, 0, 1, 0, 0, 0, 24'hDFF180);
    vecs[11] = mk(0, 1, 0, 0, 1, 0, 0, 0, 24'hDFF180);
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      a_valid = vecs[i].a_valid;
      bg_n = vecs[i].bg_n;
      eng_done = vecs[i].eng_done;
      #1;
      chk($sformatf("v%0d_br", i), br_drive, vecs[i].br);
      chk($sformatf("v%0d_bgack", i), bgack_drive, vecs[i].bgack);
      chk($sformatf("v%0d_owned", i), owned, vecs[i].bgack);
      chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].a_rdy);
      chk($sformatf("v%0d_b_ready", i), b_ready, 0);
      chk($sformatf("v%0d_start", i), eng_start, vecs[i].start);
      chk($sformatf("v%0d_src", i), eng_src, vecs[i].src);
      chk($sformatf("v%0d_addr", i), eng_addr, vecs[i].addr);
      if (i == 7) begin
        chk("v7_fc", eng_fc, 5);
        chk("v7_read", eng_read, 0);
        chk("v7_wdata", eng_wdata, 32'h12345678);
      end
      $display("vec %0d: br=%0b bgack=%0b a_ready=%0b start=%0b addr=%h",
               i, br_drive, bgack_drive, a_ready, eng_start, eng_addr);
    end
    eng_done = 1'b0;

    // Starvation: both valid continuously -> AAAAB AAAAB
    do_reset();
    a_addr = 24'h100000;
    a_valid = 1; b_valid = 1;
    acquire();
    exp_grant = 10'b1000010000;  // bit k = 1 means grant k goes to B
    grants = 0; done_cnt = 0; last_b = 0; n = 0;
    while (grants < 10 && n < 300) begin
      eng_done = 1'b0;
      if (done_cnt == 1) eng_done = 1'b1;
      if (done_cnt > 0) done_cnt--;
      if (eng_start) begin
        done_cnt = 2;
        chk("starve_src", eng_src, last_b);
        chk("starve_addr", eng_addr, last_b ? 24'h200000 : 24'h100000);
      end
      if (a_ready || b_ready) begin
        chk("one_ready", a_ready & b_ready, 0);
        chk($sformatf("grant%0d_is_b", grants), b_ready, exp_grant[grants]);
        $display("grant %0d: %s", grants, b_ready ? "B" : "A");
        last_b = b_ready;
        grants++;
      end
      @(negedge sys_clk);
      n++;
    end
    chk("starve_grants", grants, 10);
    a_valid = 0; b_valid = 0; eng_done = 0;

    // Bus-grant timeout with BG never asserted
    do_reset();
    a_valid = 1; bg_n = 1;
    @(negedge sys_clk);
    chk("to_br_up", br_drive, 1);
    n = 0;
    while (!bg_timeout_err && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    $display("timeout: err after %0d REQ_BUS cycles", n);
    chk("to_cycles", n, 1023);
    chk("to_br_drop", br_drive, 0);
    a_valid = 0;
    repeat (3) @(negedge sys_clk);
    chk("to_idle_br", br_drive, 0);
    chk("to_idle_bgack", bgack_drive, 0);
    chk("to_sticky", bg_timeout_err, 1);

    // Idle hold: single transfer, then quiet
    do_reset();
    a_addr = 24'h0ABCDE;
    a_valid = 1;
    acquire();
    wait_ready();
    @(negedge sys_clk);
    a_valid = 0;
    chk("hold_start_lat", eng_start, 1);
    @(negedge sys_clk);
    eng_done = 1'b1;
    @(negedge sys_clk);
    eng_done = 1'b0;
    n = 0;
    while (bgack_drive && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    $display("hold: bgack dropped %0d cycles after done edge", n);
    chk("hold_cycles", n, 17);
    chk("hold_owned", owned, 0);
    chk("hold_br", br_drive, 0);

    // Engine busy at accept (port B), then reset during WAIT_DONE
    do_reset();
    b_addr = 24'h345678;
    b_valid = 1; eng_busy = 1;
    acquire();
    wait_ready();
    chk("busy_b_ready", b_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      b_valid = 0;
      b_addr = 24'hFFFFFF;
      chk("busy_no_start", eng_start, 0);
      chk("busy_addr", eng_addr, 24'h345678);
      chk("busy_src", eng_src, 1);
    end
    eng_busy = 0;
    @(negedge sys_clk);
    chk("busy_start", eng_start, 1);
    chk("busy_start_addr", eng_addr, 24'h345678);
    chk("busy_start_wdata", eng_wdata, 32'hCAFEF00D);
    @(negedge sys_clk);
    chk("busy_start_pulse", eng_start, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("abort_bgack", bgack_drive, 0);
    chk("abort_owned", owned, 0);
    chk("abort_br", br_drive, 0);
    chk("abort_src", eng_src, 0);
    chk("abort_addr", eng_addr, 0);
    eng_done = 1'b1;
    @(negedge sys_clk);
    eng_done = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (eng_start || bgack_drive || br_drive) n++;
    end
    chk("abort_quiet", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
